// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad front-end encoder.
// The debounce tracker uses NONE_CODE to mark "no key" next to the real key codes 0..9.
package keypad_pkg;

  localparam int KEYS = 10;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } state_t;

  localparam bcd_t NONE_CODE = 4'hF;

  // Collapse a classifier result into one code: real keys keep their index, everything else is NONE_CODE.
  function automatic bcd_t class_code(input logic is_none, input bcd_t idx);
    bcd_t code;
    if (is_none) begin
      code = NONE_CODE;
    end else begin
      code = idx;
    end
    return code;
  endfunction

endpackage

// File: rtl/decimal_to_bcd_checker.sv
// Runtime properties of the encoder outputs.
// The strobe is one cycle wide, and only decimal digits are ever shown on y.
module decimal_to_bcd_checker (
  input logic       i_clk,
  input logic       i_rst_n,
  input logic [3:0] i_y,
  input logic       i_loadn
);

  a_single_strobe : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !i_loadn |=> i_loadn);

  a_digit_range : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_y <= 4'd9);

endmodule

// File: rtl/onehot_to_bin.sv
// Combinational classifier for the 10-line keypad bus.
// Gives the index of a single pressed key, and flags the all-released case.
module onehot_to_bin
  import keypad_pkg::*;
(
  input  logic [KEYS-1:0] i_d,
  output logic            o_valid,
  output logic            o_none,
  output bcd_t            o_idx
);

  logic [3:0] w_cnt;

  // Count the asserted lines and remember the position of the highest one.
  always_comb begin
    w_cnt = 4'd0;
    o_idx = 4'd0;
    for (int k = 32'sd0; k < KEYS; k++) begin
      if (i_d[k]) begin
        w_cnt = w_cnt + 4'd1;
        o_idx = 4'(k);
      end else begin
        w_cnt = w_cnt;
      end
    end
  end

  assign o_valid = (w_cnt == 4'd1);
  assign o_none  = (w_cnt == 4'd0);

endmodule

// File: rtl/decimal_to_bcd.sv
// Keypad front-end: synchronizes the one-hot keypad bus, debounces it and issues one
// active-low load strobe with the BCD digit for each accepted press.
module decimal_to_bcd
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  d,
  input  logic        enable,
  output logic [3:0]  y,
  output logic        loadn
);

  localparam logic [7:0] DEB = 8'(DEBOUNCE_CYCLES);

  logic [KEYS-1:0] r_d_s1;
  logic [KEYS-1:0] r_d_s2;
  logic            r_en_s1;
  logic            r_en_s2;
  bcd_t            r_cls;
  logic [7:0]      r_cnt;
  state_t          r_state;
  bcd_t            r_y;
  logic            r_loadn;

  logic            w_valid;
  logic            w_none;
  bcd_t            w_idx;
  bcd_t            w_cls;
  logic            w_stable;
  logic            w_key_stable;
  logic            w_none_stable;

  // Two-flop synchronizers for the asynchronous keypad lines and enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_s1  <= 10'd0;
      r_d_s2  <= 10'd0;
      r_en_s1 <= 1'b0;
      r_en_s2 <= 1'b0;
    end else begin
      r_d_s1  <= d;
      r_d_s2  <= r_d_s1;
      r_en_s1 <= enable;
      r_en_s2 <= r_en_s1;
    end
  end

  onehot_to_bin u_classify (
    .i_d     (r_d_s2),
    .o_valid (w_valid),
    .o_none  (w_none),
    .o_idx   (w_idx)
  );

  // Multi-key patterns fold into NONE so they can never look like a press.
  assign w_cls         = class_code(w_none || !w_valid, w_idx);
  assign w_stable      = (w_cls == r_cls) && (r_cnt >= DEB);
  assign w_key_stable  = w_stable && (w_cls != NONE_CODE);
  assign w_none_stable = w_stable && (w_cls == NONE_CODE);

  // Debounce tracker: restarts on every class change, saturates once the pattern is stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cls <= NONE_CODE;
      r_cnt <= 8'd0;
    end else if (r_en_s2) begin
      r_cls <= w_cls;
      r_cnt <= 8'd0;
    end else if (w_cls != r_cls) begin
      r_cls <= w_cls;
      r_cnt <= 8'd1;
    end else if (r_cnt < DEB) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Press/release FSM with registered digit and load strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_y     <= 4'd0;
      r_loadn <= 1'b1;
    end else begin
      r_loadn <= 1'b1;
      if (r_en_s2) begin
        r_state <= IDLE;
        r_y     <= r_y;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_key_stable) begin
              r_state <= PRESSED;
              r_y     <= w_cls;
              r_loadn <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end
          PRESSED: begin
            // A different stable key while held is ignored; only a full release re-arms.
            if (w_none_stable) begin
              r_state <= IDLE;
            end else begin
              r_state <= PRESSED;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign y     = r_y;
  assign loadn = r_loadn;

  decimal_to_bcd_checker u_checker (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_y     (r_y),
    .i_loadn (r_loadn)
  );

endmodule

// File: tb/tb_decimal_to_bcd.sv
// Scoreboard bench for decimal_to_bcd: a cycle reference model predicts every strobe,
// and an independent monitor checks the DUT outputs against the predictions.
module tb_decimal_to_bcd;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] d = 10'd0;
  logic       enable = 1'b0;
  logic [3:0] y;
  logic       loadn;

  always #5 clk = ~clk;

  decimal_to_bcd #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (d),
    .enable (enable),
    .y      (y),
    .loadn  (loadn)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobes = 0;
  int last_strobe_cyc = -1;

  typedef struct {
    int         at;
    logic [3:0] val;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Key number of a pattern, or -1 when it is not exactly one key.
  function automatic int key_of(input logic [9:0] v);
    if ($countones(v) == 1) return $clog2(v);
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: inputs reach the decision two edges late; a key (or release) counts
  // once the same value has been seen on more than DEB consecutive enabled edges.
  logic [9:0] m_d1 = 10'd0, m_d2 = 10'd0;
  logic       m_e1 = 1'b0, m_e2 = 1'b0;
  int         m_prev = -1;
  int         m_run = 0;
  bit         m_pressed = 1'b0;
  logic [3:0] m_y = 4'd0;
  int         w_k;
  int         w_run;
  assign w_k   = key_of(m_d2);
  assign w_run = (w_k == m_prev) ? m_run + 1 : 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_d1 <= 10'd0; m_d2 <= 10'd0; m_e1 <= 1'b0; m_e2 <= 1'b0;
      m_prev <= -1; m_run <= 0; m_pressed <= 1'b0; m_y <= 4'd0;
    end else begin
      m_d1 <= d; m_d2 <= m_d1; m_e1 <= enable; m_e2 <= m_e1;
      m_prev <= w_k;
      if (m_e2) begin
        m_run <= 0;
        m_pressed <= 1'b0;
      end else begin
        m_run <= w_run;
        if (!m_pressed && w_k >= 0 && w_run > DEB) begin
          m_pressed <= 1'b1;
          m_y <= 4'(w_k);
          sb.push_back('{cyc + 1, 4'(w_k)});
        end else if (m_pressed && w_k < 0 && w_run > DEB) begin
          m_pressed <= 1'b0;
        end
      end
    end
  end

  // Monitor: compares the DUT against the model on every falling edge.
  logic prev_loadn = 1'b1;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("y_track", int'(y), int'(m_y));
      if (loadn === 1'b0) begin
        strobes++;
        last_strobe_cyc = cyc;
        chk("no_double_strobe", int'(prev_loadn), 1);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: loadn low with y=%0d, none expected (cycle %0d)", y, cyc);
        end else begin
          e = sb.pop_front();
          chk("strobe_cycle", cyc, e.at);
          chk("strobe_y", int'(y), int'(e.val));
        end
      end else if (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++; errors++;
        $display("FAIL missed_strobe: loadn high, expected strobe y=%0d at cycle %0d", e.val, e.at);
      end
      prev_loadn = loadn;
    end
  end

  task automatic drive(input logic [9:0] v, input int n);
    d = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int keys[3] = '{4, 3, 6};
    int s0;
    int c0;
    logic [9:0] one = 10'd1;
    logic [9:0] v;
    int a, b, kind;

    repeat (3) @(negedge clk);
    chk("reset_y", int'(y), 0);
    chk("reset_loadn", int'(loadn), 1);
    rst_n = 1'b1;
    drive(10'd0, 10);

    foreach (keys[i]) begin
      s0 = strobes;
      c0 = cyc;
      drive(one << keys[i], 20);
      chk("key_latency", last_strobe_cyc - c0, DEB + 3);
      drive(10'd0, 20);
      chk("key_one_strobe", strobes - s0, 1);
      chk("key_y_held", int'(y), keys[i]);
    end

    s0 = strobes;
    drive(one << 9, 50);
    chk("hold9_strobes", strobes - s0, 1);
    chk("hold9_y", int'(y), 9);
    drive(10'd0, 20);

    s0 = strobes;
    drive(one << 7, DEB - 1);
    drive(10'd0, 20);
    chk("glitch_no_strobe", strobes - s0, 0);
    chk("glitch_y", int'(y), 9);

    s0 = strobes;
    drive(10'b0000000110, 20);
    chk("invalid_no_strobe", strobes - s0, 0);
    drive(10'd0, 10);
    drive(one << 2, 20);
    chk("after_invalid_strobe", strobes - s0, 1);
    chk("after_invalid_y", int'(y), 2);
    drive(10'd0, 20);

    enable = 1'b1;
    drive(10'd0, 4);
    s0 = strobes;
    drive(one << 5, 20);
    chk("disabled_no_strobe", strobes - s0, 0);
    enable = 1'b0;
    c0 = cyc;
    drive(one << 5, 20);
    chk("enable_strobe", strobes - s0, 1);
    chk("enable_latency", last_strobe_cyc - c0, DEB + 3);
    chk("enable_y", int'(y), 5);
    drive(10'd0, 20);

    drive(one << 8, DEB + 6);
    chk("pre_reset_y", int'(y), 8);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_y", int'(y), 0);
    chk("async_reset_loadn", int'(loadn), 1);
    @(negedge clk);
    s0 = strobes;
    rst_n = 1'b1;
    c0 = cyc;
    drive(one << 8, 20);
    chk("post_reset_strobe", strobes - s0, 1);
    chk("post_reset_latency", last_strobe_cyc - c0, DEB + 3);
    drive(10'd0, 20);

    repeat (300) begin
      kind = $urandom_range(0, 9);
      a = $urandom_range(0, 9);
      b = (a + $urandom_range(1, 9)) % 10;
      if (kind <= 4) v = one << a;
      else if (kind <= 6) v = 10'd0;
      else if (kind == 7) v = (one << a) | (one << b);
      else if (kind == 8) begin
        enable = ~enable;
        v = d;
      end else v = 10'($urandom_range(0, 1023));
      drive(v, $urandom_range(1, 2 * DEB + 4));
    end
    enable = 1'b0;
    drive(10'd0, 30);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
